// File: rtl/fifo_8bit_rd.sv
// rtl/fifo_8bit_rd.sv - byte FIFO read side with registered output and valid strobe; FIFO_ERR_FLAGS_EN adds sticky ovf/udf
module fifo_8bit_rd #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             re_n,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic             ovf,
    output logic             udf
`endif
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_next;
    logic             wr_acc;
    logic             rd_acc;

    // A write into a full FIFO is still taken when a read frees a slot on the same edge.
    assign rd_acc = !re_n && !empty;
    assign wr_acc = !we_n && (!full || rd_acc);

    always_comb begin
        count_next = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count + {{AW{1'b0}}, 1'b1};
            2'b01:   count_next = count - {{AW{1'b0}}, 1'b1};
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
            valid    <= 1'b0;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            if (rd_acc) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            valid <= rd_acc;
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (!we_n && full && !rd_acc) begin
                ovf <= 1'b1;
            end
            if (!re_n && empty) begin
                udf <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_8bit_rd.sv
// tb/tb_fifo_8bit_rd.sv - directed self-checking bench for fifo_8bit_rd
module tb_fifo_8bit_rd;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       we_n;
    logic [7:0] data_in;
    logic       re_n;
    logic [7:0] data_out;
    logic       valid;
    logic       full;
    logic       empty;
    logic [3:0] count;
`ifdef FIFO_ERR_FLAGS_EN
    logic       ovf;
    logic       udf;
`endif

    int total = 0;
    int bad   = 0;

    fifo_8bit_rd #(.WIDTH(8), .DEPTH(8), .AW(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_n     (we_n),
        .data_in  (data_in),
        .re_n     (re_n),
        .data_out (data_out),
        .valid    (valid),
        .full     (full),
        .empty    (empty),
        .count    (count)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .ovf      (ovf),
        .udf      (udf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic [7:0] d, input logic r);
        @(negedge clk);
        we_n    = w;
        data_in = d;
        re_n    = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_b;
        int         nvalid;

        rst_n   = 1'b0;
        we_n    = 1'b1;
        re_n    = 1'b1;
        data_in = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_valid", valid, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_count", count, 4'd0);

        // Fill 0x01..0x08, then overflow attempt
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 8'(i), 1'b1);
            chk("fill_count", count, 32'(i));
            chk("fill_empty", empty, 1'b0);
        end
        chk("fill_full", full, 1'b1);
        cyc(1'b0, 8'hFF, 1'b1);
        chk("ovf_write_count", count, 4'd8);
        chk("ovf_write_full", full, 1'b1);
`ifdef FIFO_ERR_FLAGS_EN
        chk("ovf_flag", ovf, 1'b1);
`endif
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 8'h00, 1'b0);
            chk("drain_data", data_out, 32'(i));
            chk("drain_valid", valid, 1'b1);
            chk("drain_count", count, 32'(8 - i));
        end
        chk("drain_empty", empty, 1'b1);
        chk("drain_full", full, 1'b0);
        cyc(1'b1, 8'h00, 1'b0);
        chk("rd_empty_valid", valid, 1'b0);
        chk("rd_empty_hold", data_out, 8'h08);
        chk("rd_empty_count", count, 4'd0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("udf_flag", udf, 1'b1);
`endif

        // Asynchronous reset between clock edges
        cyc(1'b0, 8'h33, 1'b1);
        chk("pre_async_count", count, 4'd1);
        #3;
        rst_n = 1'b0;
        #2;
        chk("async_data_out", data_out, 8'h00);
        chk("async_count", count, 4'd0);
        chk("async_empty", empty, 1'b1);
        chk("async_valid", valid, 1'b0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("async_ovf", ovf, 1'b0);
        chk("async_udf", udf, 1'b0);
`endif
        @(negedge clk);
        we_n  = 1'b1;
        re_n  = 1'b1;
        rst_n = 1'b1;

        // Wrap-around: reads trail writes by three entries
        for (int k = 0; k < 23; k++) begin
            cyc((k < 20) ? 1'b0 : 1'b1, 8'(k), (k >= 3) ? 1'b0 : 1'b1);
            if (k >= 3) begin
                chk("wrap_data", data_out, 32'(k - 3));
                chk("wrap_valid", valid, 1'b1);
            end
            chk("wrap_count", 32'(count <= 4'd3), 32'd1);
        end
        chk("wrap_empty", empty, 1'b1);

        // Simultaneous read and write at full
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 8'(8'h10 + i), 1'b1);
        end
        cyc(1'b0, 8'h18, 1'b0);
        chk("simfull_data", data_out, 8'h10);
        chk("simfull_count", count, 4'd8);
        chk("simfull_full", full, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 8'h00, 1'b0);
            chk("simfull_drain", data_out, 32'(8'h10 + i));
        end
        chk("simfull_empty", empty, 1'b1);

        // Simultaneous read and write at empty: no bypass
        cyc(1'b0, 8'hA5, 1'b0);
        chk("simempty_valid", valid, 1'b0);
        chk("simempty_count", count, 4'd1);
        chk("simempty_hold", data_out, 8'h18);
        cyc(1'b1, 8'h00, 1'b0);
        chk("simempty_data", data_out, 8'hA5);
        chk("simempty_valid2", valid, 1'b1);
        chk("simempty_count2", count, 4'd0);

        // Toggling write strobe with continuous reads
        nvalid = 0;
        for (int i = 0; i < 256; i++) begin
            logic w;
            w = (i >= 5 && i <= 10) ? 1'(i % 2) : 1'b0;
            cyc(w, 8'(i), 1'b0);
            if (!w) q.push_back(8'(i));
            if (valid) begin
                nvalid++;
                exp_b = (q.size() > 0) ? q.pop_front() : 8'hxx;
                chk("toggle_data", data_out, exp_b);
            end
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8'h00, 1'b0);
            if (valid) begin
                nvalid++;
                exp_b = (q.size() > 0) ? q.pop_front() : 8'hxx;
                chk("toggle_tail", data_out, exp_b);
            end
        end
        chk("toggle_nvalid", nvalid, 253);
        chk("toggle_last", data_out, 8'hFF);
        chk("toggle_empty", empty, 1'b1);
`ifdef FIFO_ERR_FLAGS_EN
        chk("toggle_ovf", ovf, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_8bit_rd.md
Name: fifo_8bit_rd

Overview:
- Synchronous FIFO that is the read side for the 8-bit register write interface, which uses an active-low write strobe `we_n` and `data_in`.
- Producer writes bytes with `we_n` low; consumer drains them with active-low `re_n` and a registered output plus `valid` flag.
- Decouples a byte producer from a slower or bursty consumer on the same clock.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 8, number of entries; must be a power of 2, ≥2.
- AW, 3, pointer width = log2(DEPTH); must match DEPTH.

Ports:
- clk  input  1  system clock, rising edge active.
- rst_n  input  1  asynchronous active-low reset.
- we_n  input  1  active-low write strobe; `data_in` is captured on a rising clk while low.
- data_in  input  WIDTH  write data.
- re_n  input  1  active-low read request.
- data_out  output  WIDTH  registered read data.
- valid  output  1  high for exactly one cycle after each accepted read; `data_out` is valid while high.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (`rst_n` low, asynchronous, any time including mid-burst):
  - wr_ptr=0, rd_ptr=0, count=0.
  - data_out=0, valid=0, full=0, empty=1.
  - Memory contents are don't-care.
- Write accept: `wr_acc` = !we_n && (!full || rd_acc).
  - On acc: mem[wr_ptr] <= data_in; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- Read accept: `rd_acc` = !re_n && !empty.
  - On acc: data_out <= mem[rd_ptr]; rd_ptr <= rd_ptr+1, wrapping; valid <= 1.
  - Otherwise: valid <= 0; data_out holds its last value.
- Read latency: 1 cycle. Data appears at the edge after re_n is sampled low; `valid` is asserted in the same cycle.
- count update:
  - +1 if wr_acc only.
  - -1 if rd_acc only.
  - Unchanged if both or neither.
- full and empty are registered and derived from the next count. They change in the same cycle as count.
- Simultaneous read and write:
  - When full: both accepted; count stays DEPTH; full stays 1.
  - When empty: write accepted, read rejected (no bypass); valid=0 next cycle; count becomes 1.
  - Otherwise: both accepted; count unchanged.
- Write while full with no read: data dropped; pointers and count unchanged.
- Read while empty: ignored; valid=0; data_out unchanged.
- Pointer wrap: rd_ptr and wr_ptr wrap from DEPTH-1 to 0 with no gap; ordering is strictly FIFO.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- When defined, two extra outputs are added:
  - `ovf` (1 bit): sticky; set on the edge where we_n=0 && full && !rd_acc.
  - `udf` (1 bit): sticky; set on the edge where re_n=0 && empty.
  - Both reset to 0 and are cleared only by rst_n.
  - Drop and ignore behaviour is otherwise identical.
- When undefined: `ovf` and `udf` ports and logic are absent. Core behaviour is unchanged.

Test Plan:
- Reset check: hold rst_n=0, then release → data_out=0x00, valid=0, empty=1, full=0, count=0. Assert rst_n=0 mid-cycle → outputs clear without waiting for a clk edge.
- Fill and drain: write 0x01..0x08 on consecutive negedges with re_n=1 → full=1, count=8. Ninth write of 0xFF is dropped (ovf=1 if enabled). Read 8 times → data_out sequence 0x01..0x08, each with valid=1 one cycle after its request. Afterwards empty=1.
- Wrap-around: 20 cycles of write i (i=0..19) interleaved with reads lagging 3 entries → read sequence 0..19 in order across two pointer wraps; count never exceeds 3.
- Simultaneous at full: fill with 0x10..0x17, then we_n=0 and re_n=0 with data_in=0x18 → data_out=0x10, count stays 8. Later drain ends with 0x18.
- Simultaneous at empty: empty FIFO, we_n=0 and re_n=0 with data_in=0xA5 → valid=0, count=1. Next read → data_out=0xA5, valid=1.
- Toggling write enable: reproduce the producer pattern: data_in=i for i=0..255, we_n toggled each cycle for i=5..10, continuous reads → only accepted bytes emerge, in order, with no duplicates. With the macro enabled, no udf or ovf is raised while the FIFO is neither empty nor full.
